gray_rx: RTL and testbench

- Receiving end of the team's Gray-code counter interface.
- Samples a Gray-coded count stream qualified by Valid and decodes it to binary.
- Checks that each new code is a legal single Gray step from the previous one, reports direction, wrap-around and sticky overflow/error.
- Sits on the consumer side of any Gray-counter producer, e.g. across a loosely coupled boundary, as a decoder plus protocol checker.

---
 rtl/gray_pkg.sv | 24 ++
 rtl/gray2bin_dec.sv | 13 +
 rtl/gray_rx.sv | 133 +++++++++++++
 tb/tb_gray_rx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code receiver: FSM state encoding,
// an all-ones constant and a width-generic Gray-to-binary decode function.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        ERR
    } state_e;

    localparam int GRAY_MAX_W = 32;
    localparam logic [GRAY_MAX_W-1:0] ALL_ONES = '1;

    // Narrower codes are zero-extended by the caller; leading zeros decode to zeros.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// Combinational Gray-to-binary decoder of a configurable width.
module gray2bin_dec
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] binary_o
);

    assign binary_o = WIDTH'(gray2bin(GRAY_MAX_W'(gray_i)));

endmodule

// File: rtl/gray_rx.sv
// Gray-code counter receiver: decodes a Valid-qualified Gray stream and checks
// that each new code is a single step. Backward steps are legal only when
// GRAY_RX_BACKWARD_EN is defined.
module gray_rx
    import gray_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [WIDTH-1:0] GrayIn,
    input  logic             Resync,
    output logic [WIDTH-1:0] Binary,
    output logic             Locked,
    output logic             Step,
    output logic             Dir,
    output logic             Wrap,
    output logic             Overflow,
    output logic [CNT_W-1:0] WrapCount,
    output logic             Error
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(ALL_ONES);
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q;
    logic [WIDTH-1:0] binary_q;
    logic             step_q;
    logic             dir_q;
    logic             wrap_q;
    logic             overflow_q;
    logic [CNT_W-1:0] wrapCount_q;
    logic             error_q;

    logic [WIDTH-1:0] curBin;
    logic [WIDTH-1:0] upBin;

    gray2bin_dec #(
        .WIDTH(WIDTH)
    ) u_dec (
        .gray_i  (GrayIn),
        .binary_o(curBin)
    );

    assign upBin = binary_q + WIDTH'(1);

`ifdef GRAY_RX_BACKWARD_EN
    logic [WIDTH-1:0] downBin;
    assign downBin = binary_q - WIDTH'(1);
`endif

    // Pulses default low each cycle; Resync outranks the per-state handling.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            binary_q    <= '0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            wrap_q      <= 1'b0;
            overflow_q  <= 1'b0;
            wrapCount_q <= '0;
            error_q     <= 1'b0;
        end else begin
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            if (Resync) begin
                error_q    <= 1'b0;
                overflow_q <= 1'b0;
                if (Valid) begin
                    state_q  <= TRACK;
                    binary_q <= curBin;
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (Valid) begin
                            state_q  <= TRACK;
                            binary_q <= curBin;
                        end
                    end
                    TRACK: begin
                        if (Valid && (curBin != binary_q)) begin
                            if (curBin == upBin) begin
                                step_q   <= 1'b1;
                                dir_q    <= 1'b1;
                                binary_q <= curBin;
                                if (binary_q == MaxVal) begin
                                    wrap_q     <= 1'b1;
                                    overflow_q <= 1'b1;
                                    if (wrapCount_q != CntMax) begin
                                        wrapCount_q <= wrapCount_q + CNT_W'(1);
                                    end
                                end
`ifdef GRAY_RX_BACKWARD_EN
                            end else if (curBin == downBin) begin
                                step_q   <= 1'b1;
                                dir_q    <= 1'b0;
                                binary_q <= curBin;
                                if (binary_q == '0) begin
                                    wrap_q <= 1'b1;
                                end
`endif
                            end else begin
                                error_q <= 1'b1;
                                state_q <= ERR;
                            end
                        end
                    end
                    ERR: begin
                        state_q <= ERR;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign Binary    = binary_q;
    assign Locked    = (state_q == TRACK);
    assign Step      = step_q;
    assign Dir       = dir_q;
    assign Wrap      = wrap_q;
    assign Overflow  = overflow_q;
    assign WrapCount = wrapCount_q;
    assign Error     = error_q;

endmodule

// File: tb/tb_gray_rx.sv
// Scoreboard bench for gray_rx: directed scenarios plus random beats, checked
// against a counting model; honours GRAY_RX_BACKWARD_EN like the design.
module tb_gray_rx;

    localparam int W    = 3;
    localparam int CW   = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        int binary;
        int locked;
        int step;
        int dir;
        int wrap;
        int overflow;
        int wrapCount;
        int error;
    } exp_t;

    logic          Clk;
    logic          Reset;
    logic          Valid;
    logic [W-1:0]  GrayIn;
    logic          Resync;
    logic [W-1:0]  Binary;
    logic          Locked;
    logic          Step;
    logic          Dir;
    logic          Wrap;
    logic          Overflow;
    logic [CW-1:0] WrapCount;
    logic          Error;

    exp_t scoreQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: value held, whether a reference exists, whether errored.
    int mBin   = 0;
    int mCnt   = 0;
    bit mRef   = 0;
    bit mErr   = 0;
    bit mDir   = 0;
    bit mOvf   = 0;
    bit mStep  = 0;
    bit mWrap  = 0;

    gray_rx #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Valid    (Valid),
        .GrayIn   (GrayIn),
        .Resync   (Resync),
        .Binary   (Binary),
        .Locked   (Locked),
        .Step     (Step),
        .Dir      (Dir),
        .Wrap     (Wrap),
        .Overflow (Overflow),
        .WrapCount(WrapCount),
        .Error    (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int toGray(int b);
        return (b ^ (b >> 1)) & MAXV;
    endfunction

    function automatic int fromGray(int g);
        int b;
        b = 0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b & MAXV;
    endfunction

    function automatic bit backwardLegal();
`ifdef GRAY_RX_BACKWARD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelBeat(input bit rst, input bit vld, input int g, input bit rsy);
        int cur;
        int diff;
        cur   = fromGray(g);
        mStep = 0;
        mWrap = 0;
        if (rst) begin
            mBin = 0; mCnt = 0; mRef = 0; mErr = 0; mDir = 0; mOvf = 0;
        end else if (rsy) begin
            mErr = 0;
            mOvf = 0;
            mRef = vld;
            if (vld) mBin = cur;
        end else if (mErr) begin
            mErr = 1;
        end else if (!mRef) begin
            if (vld) begin
                mRef = 1;
                mBin = cur;
            end
        end else if (vld) begin
            diff = (cur - mBin + (1 << W)) % (1 << W);
            if (diff == 1) begin
                mStep = 1;
                mDir  = 1;
                if (mBin == MAXV) begin
                    mWrap = 1;
                    mOvf  = 1;
                    if (mCnt < CMAX) mCnt++;
                end
                mBin = cur;
            end else if (diff == MAXV && backwardLegal()) begin
                mStep = 1;
                mDir  = 0;
                if (mBin == 0) mWrap = 1;
                mBin = cur;
            end else if (diff != 0) begin
                mErr = 1;
                mRef = 0;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit vld, input int g, input bit rsy);
        exp_t e;
        @(negedge Clk);
        Reset  = rst;
        Valid  = vld;
        GrayIn = g[W-1:0];
        Resync = rsy;
        modelBeat(rst, vld, g, rsy);
        e.binary    = mBin;
        e.locked    = (mRef && !mErr) ? 1 : 0;
        e.step      = mStep;
        e.dir       = mDir;
        e.wrap      = mWrap;
        e.overflow  = mOvf;
        e.wrapCount = mCnt;
        e.error     = mErr;
        scoreQ.push_back(e);
    endtask

    task automatic checkField(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("Binary",    int'(Binary),    e.binary);
        checkField("Locked",    int'(Locked),    e.locked);
        checkField("Step",      int'(Step),      e.step);
        checkField("Dir",       int'(Dir),       e.dir);
        checkField("Wrap",      int'(Wrap),      e.wrap);
        checkField("Overflow",  int'(Overflow),  e.overflow);
        checkField("WrapCount", int'(WrapCount), e.wrapCount);
        checkField("Error",     int'(Error),     e.error);
    endtask

    // Monitor: registered outputs are presented every cycle after an issued beat.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (scoreQ.size() > 0) begin
                e = scoreQ.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic randomBeat();
        bit rst;
        bit vld;
        bit rsy;
        int k;
        int g;
        rst = ($urandom_range(0, 99) < 2);
        rsy = ($urandom_range(0, 99) < 4);
        vld = ($urandom_range(0, 3) != 0);
        k   = $urandom_range(0, 9);
        if (k < 5)       g = toGray(mBin + 1);
        else if (k < 7)  g = toGray(mBin + MAXV);
        else if (k < 8)  g = toGray(mBin);
        else             g = $urandom_range(0, MAXV);
        applyStimulus(rst, vld, g, rsy);
    endtask

    initial begin
        int lap[9];
        lap = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
        Reset  = 1'b1;
        Valid  = 1'b0;
        GrayIn = '0;
        Resync = 1'b0;

        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);

        $display("[TB] forward lap");
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, lap[i], 0);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] illegal jump and resync");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 3, 0);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 2, 0);
        applyStimulus(0, 1, 3, 1);
        applyStimulus(0, 1, 2, 0);

        $display("[TB] backward step");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 3, 0);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 4, 0);

        $display("[TB] hold and gaps");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, (i % 2) == 0, 2, 0);

        $display("[TB] saturation");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        for (int i = 1; i <= 16 * 8; i++) applyStimulus(0, 1, toGray(i), 0);

        $display("[TB] reset mid-stream");
        applyStimulus(0, 1, 0, 1);
        for (int i = 1; i <= 5; i++) applyStimulus(0, 1, toGray(i), 0);
        applyStimulus(1, 1, toGray(6), 0);
        applyStimulus(0, 1, 6, 0);
        applyStimulus(0, 0, 6, 0);

        $display("[TB] random beats");
        for (int i = 0; i < 2000; i++) randomBeat();

        applyStimulus(0, 0, 0, 0);
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (scoreQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: actual=%0d pending expected=0", scoreQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
